axi4l_reg_slave: RTL and testbench

//  AXI4-Lite subordinate (responder) exposing NUM_REGS 32-bit read/write control registers at BASE_ADDR.
//  It is the target end of the SoC AXI4-Lite fabric that the CV32E40P-side interconnect drives.

---
 rtl/axi4l_reg_slave.sv | 197 +++++++++++++++++++
 tb/tb_axi4l_reg_slave.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit control registers at BASE_ADDR.
// Optional byte-strobe writes are enabled with the AXI4L_REG_SLAVE_WSTRB_EN macro.
module axi4l_reg_slave #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 32'h2000_0000,
  parameter int unsigned            NUM_REGS   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr_i,
  input  logic                           s_awvalid_i,
  output logic                           s_awready_o,
  input  logic [DATA_WIDTH-1:0]          s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb_i,
  input  logic                           s_wvalid_i,
  output logic                           s_wready_o,
  output logic [1:0]                     s_bresp_o,
  output logic                           s_bvalid_o,
  input  logic                           s_bready_i,
  input  logic [ADDR_WIDTH-1:0]          s_araddr_i,
  input  logic                           s_arvalid_i,
  output logic                           s_arready_o,
  output logic [DATA_WIDTH-1:0]          s_rdata_o,
  output logic [1:0]                     s_rresp_o,
  output logic                           s_rvalid_o,
  input  logic                           s_rready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]            reg_wr_pulse_o
);

  localparam int unsigned           IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned           STRB_W      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES   = ADDR_WIDTH'(4 * NUM_REGS);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

  w_state_e                           w_state_r, w_state_s;
  r_state_e                           r_state_r, r_state_s;
  logic                               rst_done_r;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_r;
  logic [NUM_REGS-1:0]                pulse_r;
  logic                               aw_held_r, w_held_r;
  logic [ADDR_WIDTH-1:0]              awaddr_r;
  logic [DATA_WIDTH-1:0]              wdata_r;
  logic [STRB_W-1:0]                  wstrb_r;
  logic                               bvalid_r, rvalid_r;
  logic [1:0]                         bresp_r, rresp_r;
  logic [DATA_WIDTH-1:0]              rdata_r;

  logic                  aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, r_hs_s;
  logic                  aw_have_s, w_have_s, commit_s, wr_ok_s, whit_s, rhit_s;
  logic [ADDR_WIDTH-1:0] waddr_s, woff_s, roff_s;
  logic [DATA_WIDTH-1:0] wdata_s, wmerge_s;
  logic [STRB_W-1:0]     wstrb_s;
  logic [IDX_W-1:0]      widx_s, ridx_s;
  logic [1:0]            wresp_s;

  assign s_awready_o    = rst_done_r && (w_state_r == W_COLLECT) && !aw_held_r;
  assign s_wready_o     = rst_done_r && (w_state_r == W_COLLECT) && !w_held_r;
  assign s_arready_o    = rst_done_r && (r_state_r == R_IDLE);
  assign s_bvalid_o     = bvalid_r;
  assign s_bresp_o      = bresp_r;
  assign s_rvalid_o     = rvalid_r;
  assign s_rresp_o      = rresp_r;
  assign s_rdata_o      = rdata_r;
  assign reg_q_o        = regs_r;
  assign reg_wr_pulse_o = pulse_r;

  assign aw_hs_s = s_awvalid_i && s_awready_o;
  assign w_hs_s  = s_wvalid_i && s_wready_o;
  assign ar_hs_s = s_arvalid_i && s_arready_o;
  assign b_hs_s  = bvalid_r && s_bready_i;
  assign r_hs_s  = rvalid_r && s_rready_i;

  // Write decode: a channel arriving this cycle bypasses its holding register.
  always_comb begin
    aw_have_s = aw_held_r | aw_hs_s;
    w_have_s  = w_held_r | w_hs_s;
    waddr_s   = aw_held_r ? awaddr_r : s_awaddr_i;
    wdata_s   = w_held_r ? wdata_r : s_wdata_i;
    wstrb_s   = w_held_r ? wstrb_r : s_wstrb_i;
    woff_s    = waddr_s - BASE_ADDR;
    whit_s    = (waddr_s >= BASE_ADDR) && (woff_s < WIN_BYTES);
    widx_s    = woff_s[IDX_W+1:2];
    commit_s  = (w_state_r == W_COLLECT) && aw_have_s && w_have_s;
`ifdef AXI4L_REG_SLAVE_WSTRB_EN
    wr_ok_s   = whit_s;
    wresp_s   = whit_s ? RESP_OKAY : RESP_SLVERR;
    wmerge_s  = regs_r[widx_s];
    for (int b = 0; b < STRB_W; b++) begin
      wmerge_s[b*8 +: 8] = wstrb_s[b] ? wdata_s[b*8 +: 8] : regs_r[widx_s][b*8 +: 8];
    end
`else
    wr_ok_s   = whit_s && (wstrb_s == {STRB_W{1'b1}});
    wresp_s   = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
    wmerge_s  = wdata_s;
`endif
  end

  // Read decode straight from the AR channel.
  always_comb begin
    roff_s = s_araddr_i - BASE_ADDR;
    rhit_s = (s_araddr_i >= BASE_ADDR) && (roff_s < WIN_BYTES);
    ridx_s = roff_s[IDX_W+1:2];
  end

  // Write FSM next state.
  always_comb begin
    w_state_s = w_state_r;
    case (w_state_r)
      W_COLLECT: w_state_s = commit_s ? W_RESP : W_COLLECT;
      W_RESP:    w_state_s = s_bready_i ? W_COLLECT : W_RESP;
      default:   w_state_s = W_COLLECT;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    r_state_s = r_state_r;
    case (r_state_r)
      R_IDLE:  r_state_s = ar_hs_s ? R_RESP : R_IDLE;
      R_RESP:  r_state_s = s_rready_i ? R_IDLE : R_RESP;
      default: r_state_s = R_IDLE;
    endcase
  end

  // State registers and the reset-release flag that opens the readies.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_r  <= W_COLLECT;
      r_state_r  <= R_IDLE;
      rst_done_r <= 1'b0;
    end else begin
      w_state_r  <= w_state_s;
      r_state_r  <= r_state_s;
      rst_done_r <= 1'b1;
    end
  end

  // Write path: channel holding, commit into the register file, B response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_r    <= '0;
      pulse_r   <= '0;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      awaddr_r  <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      pulse_r <= '0;
      if (aw_hs_s) begin
        aw_held_r <= 1'b1;
        awaddr_r  <= s_awaddr_i;
      end
      if (w_hs_s) begin
        w_held_r <= 1'b1;
        wdata_r  <= s_wdata_i;
        wstrb_r  <= s_wstrb_i;
      end
      if (commit_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= wresp_s;
        if (wr_ok_s) begin
          regs_r[widx_s]  <= wmerge_s;
          pulse_r[widx_s] <= 1'b1;
        end
      end else if (b_hs_s) begin
        bvalid_r  <= 1'b0;
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
      end
    end
  end

  // Read path: sample the register file on the AR handshake, hold until R handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
      rresp_r  <= RESP_OKAY;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rhit_s ? regs_r[ridx_s] : '0;
      rresp_r  <= rhit_s ? RESP_OKAY : RESP_SLVERR;
    end else if (r_hs_s) begin
      rvalid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Directed self-checking bench for axi4l_reg_slave (16 registers at 0x2000_0000).
module tb_axi4l_reg_slave;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [31:0]  s_awaddr_i, s_wdata_i, s_araddr_i;
  logic         s_awvalid_i, s_wvalid_i, s_bready_i, s_arvalid_i, s_rready_i;
  logic [3:0]   s_wstrb_i;
  logic         s_awready_o, s_wready_o, s_bvalid_o, s_arready_o, s_rvalid_o;
  logic [1:0]   s_bresp_o, s_rresp_o;
  logic [31:0]  s_rdata_o;
  logic [511:0] reg_q_o;
  logic [15:0]  reg_wr_pulse_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_regs [16];

  always #5 clk_i = ~clk_i;

  axi4l_reg_slave dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .reg_q_o(reg_q_o), .reg_wr_pulse_o(reg_wr_pulse_o)
  );

  function automatic logic [511:0] exp_flat();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = exp_regs[k];
    return v;
  endfunction

  // AW and W presented together; returns the first B beat and its latency in cycles.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [15:0] pulse, output int lat);
    resp = 2'b11; pulse = 16'hFFFF; lat = 99;
    @(negedge clk_i);
    s_awaddr_i = a; s_awvalid_i = 1'b1; s_wdata_i = d; s_wstrb_i = s; s_wvalid_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
      if (s_bvalid_o === 1'b1) begin
        lat = i; resp = s_bresp_o; pulse = reg_wr_pulse_o;
        break;
      end
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    data = 32'hXXXX_XXXX; resp = 2'b11; lat = 99;
    @(negedge clk_i);
    s_araddr_i = a; s_arvalid_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      s_arvalid_i = 1'b0;
      if (s_rvalid_o === 1'b1) begin
        lat = i; data = s_rdata_o; resp = s_rresp_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    checks++; if ({s_awready_o, s_wready_o, s_arready_o} !== 3'b000) begin failures++;
      $display("FAIL rst_readies got=%b exp=000", {s_awready_o, s_wready_o, s_arready_o}); end
    checks++; if (reg_q_o !== 512'd0) begin failures++; $display("FAIL rst_reg_q got=%h exp=0", reg_q_o); end
    checks++; if ({s_bvalid_o, s_rvalid_o, reg_wr_pulse_o} !== 18'd0) begin failures++;
      $display("FAIL rst_valids got=%b%b pulse=%h exp=0", s_bvalid_o, s_rvalid_o, reg_wr_pulse_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++; if ({s_awready_o, s_wready_o, s_arready_o} !== 3'b111) begin failures++;
      $display("FAIL rel_readies got=%b exp=111", {s_awready_o, s_wready_o, s_arready_o}); end
  endtask

  task automatic test_write_read();
    logic [1:0] resp; logic [15:0] pulse; logic [31:0] data; int lat;
    do_write(32'h2000_0004, 32'hDEAD_BEEF, 4'hF, resp, pulse, lat);
    exp_regs[1] = 32'hDEAD_BEEF;
    checks++; if (lat !== 1) begin failures++; $display("FAIL wr_latency got=%0d exp=1", lat); end
    checks++; if (resp !== 2'b00) begin failures++; $display("FAIL wr_bresp got=%b exp=00", resp); end
    checks++; if (pulse !== 16'h0002) begin failures++; $display("FAIL wr_pulse got=%h exp=0002", pulse); end
    checks++; if (reg_q_o !== exp_flat()) begin failures++; $display("FAIL wr_reg_q got=%h exp=%h", reg_q_o, exp_flat()); end
    do_read(32'h2000_0004, data, resp, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL rd_latency got=%0d exp=1", lat); end
    checks++; if (data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", data); end
    checks++; if (resp !== 2'b00) begin failures++; $display("FAIL rd_rresp got=%b exp=00", resp); end
  endtask

  task automatic test_skew_backpressure();
    s_bready_i = 1'b0;
    @(negedge clk_i);
    s_awaddr_i = 32'h2000_0008; s_wdata_i = 32'hCAFE_F00D; s_wstrb_i = 4'hF; s_wvalid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      s_wvalid_i = 1'b0;
      checks++; if (s_bvalid_o !== 1'b0) begin failures++; $display("FAIL skew_early_bvalid cyc=%0d got=%b exp=0", i, s_bvalid_o); end
      checks++; if (s_wready_o !== 1'b0) begin failures++; $display("FAIL skew_wready_held cyc=%0d got=%b exp=0", i, s_wready_o); end
    end
    s_awvalid_i = 1'b1;
    @(negedge clk_i);
    s_awvalid_i = 1'b0;
    exp_regs[2] = 32'hCAFE_F00D;
    checks++; if (reg_wr_pulse_o !== 16'h0004) begin failures++; $display("FAIL skew_pulse got=%h exp=0004", reg_wr_pulse_o); end
    checks++; if (reg_q_o !== exp_flat()) begin failures++; $display("FAIL skew_reg_q got=%h exp=%h", reg_q_o, exp_flat()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({s_bvalid_o, s_bresp_o} !== 3'b100) begin failures++;
        $display("FAIL skew_b_stable cyc=%0d got=%b%b exp=100", i, s_bvalid_o, s_bresp_o); end
      checks++; if ({s_awready_o, s_wready_o} !== 2'b00) begin failures++;
        $display("FAIL skew_ready_in_resp cyc=%0d got=%b exp=00", i, {s_awready_o, s_wready_o}); end
      if (i > 0) begin
        checks++; if (reg_wr_pulse_o !== 16'h0000) begin failures++; $display("FAIL skew_pulse_width cyc=%0d got=%h exp=0000", i, reg_wr_pulse_o); end
      end
      if (i == 4) s_bready_i = 1'b1;
      @(negedge clk_i);
    end
    checks++; if ({s_bvalid_o, s_awready_o, s_wready_o} !== 3'b011) begin failures++;
      $display("FAIL skew_after_b got=%b exp=011", {s_bvalid_o, s_awready_o, s_wready_o}); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [15:0] pulse; logic [31:0] data; int lat;
    do_write(32'h2000_0040, 32'h1234_5678, 4'hF, resp, pulse, lat);
    checks++; if (resp !== 2'b10) begin failures++; $display("FAIL oor_wr_bresp got=%b exp=10", resp); end
    checks++; if (pulse !== 16'h0000) begin failures++; $display("FAIL oor_wr_pulse got=%h exp=0000", pulse); end
    checks++; if (reg_q_o !== exp_flat()) begin failures++; $display("FAIL oor_wr_reg_q got=%h exp=%h", reg_q_o, exp_flat()); end
    do_read(32'h1FFF_FFFC, data, resp, lat);
    checks++; if ({data, resp} !== {32'h0000_0000, 2'b10}) begin failures++;
      $display("FAIL oor_rd got=%h/%b exp=00000000/10", data, resp); end
    do_read(32'h2000_003C, data, resp, lat);
    checks++; if ({data, resp} !== {32'h0000_0000, 2'b00}) begin failures++;
      $display("FAIL last_reg_rd got=%h/%b exp=00000000/00", data, resp); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp, exp_resp; logic [15:0] pulse, exp_pulse; logic [31:0] data; int lat;
    do_write(32'h2000_0000, 32'hFFFF_FFFF, 4'hF, resp, pulse, lat);
    exp_regs[0] = 32'hFFFF_FFFF;
    checks++; if (resp !== 2'b00) begin failures++; $display("FAIL strb_full_bresp got=%b exp=00", resp); end
    do_write(32'h2000_0000, 32'h1122_3344, 4'b0011, resp, pulse, lat);
`ifdef AXI4L_REG_SLAVE_WSTRB_EN
    exp_resp = 2'b00; exp_pulse = 16'h0001; exp_regs[0] = 32'hFFFF_3344;
`else
    exp_resp = 2'b10; exp_pulse = 16'h0000;
`endif
    checks++; if (resp !== exp_resp) begin failures++; $display("FAIL strb_part_bresp got=%b exp=%b", resp, exp_resp); end
    checks++; if (pulse !== exp_pulse) begin failures++; $display("FAIL strb_part_pulse got=%h exp=%h", pulse, exp_pulse); end
    checks++; if (reg_q_o !== exp_flat()) begin failures++; $display("FAIL strb_reg_q got=%h exp=%h", reg_q_o, exp_flat()); end
    do_read(32'h2000_0000, data, resp, lat);
    checks++; if (data !== exp_regs[0]) begin failures++; $display("FAIL strb_rd got=%h exp=%h", data, exp_regs[0]); end
  endtask

  task automatic test_same_edge_and_reset();
    logic [1:0] resp; logic [15:0] pulse; logic [31:0] data; int lat;
    do_write(32'h2000_0008, 32'h0000_0005, 4'hF, resp, pulse, lat);
    exp_regs[2] = 32'h0000_0005;
    @(negedge clk_i);
    s_awaddr_i = 32'h2000_0008; s_wdata_i = 32'h0000_000A; s_wstrb_i = 4'hF;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
    s_araddr_i = 32'h2000_0008; s_arvalid_i = 1'b1;
    @(negedge clk_i);
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0; s_arvalid_i = 1'b0;
    exp_regs[2] = 32'h0000_000A;
    checks++; if ({s_rvalid_o, s_rdata_o} !== {1'b1, 32'h0000_0005}) begin failures++;
      $display("FAIL same_edge_old got=%b/%h exp=1/00000005", s_rvalid_o, s_rdata_o); end
    checks++; if ({s_bvalid_o, s_bresp_o} !== 3'b100) begin failures++;
      $display("FAIL same_edge_b got=%b%b exp=100", s_bvalid_o, s_bresp_o); end
    do_read(32'h2000_0008, data, resp, lat);
    checks++; if (data !== 32'h0000_000A) begin failures++; $display("FAIL same_edge_new got=%h exp=0000000a", data); end
    s_bready_i = 1'b0;
    @(negedge clk_i);
    s_awaddr_i = 32'h2000_000C; s_wdata_i = 32'h0000_0077; s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
    @(negedge clk_i);
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    checks++; if (s_bvalid_o !== 1'b1) begin failures++; $display("FAIL pre_rst_bvalid got=%b exp=1", s_bvalid_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if ({s_bvalid_o, s_awready_o, s_wready_o} !== 3'b000) begin failures++;
      $display("FAIL mid_rst_drop got=%b exp=000", {s_bvalid_o, s_awready_o, s_wready_o}); end
    checks++; if (reg_q_o !== 512'd0) begin failures++; $display("FAIL mid_rst_reg_q got=%h exp=0", reg_q_o); end
    @(negedge clk_i);
    rst_ni = 1'b1; s_bready_i = 1'b1;
    @(negedge clk_i);
    checks++; if ({s_bvalid_o, s_awready_o} !== 2'b01) begin failures++;
      $display("FAIL post_rst got=%b exp=01", {s_bvalid_o, s_awready_o}); end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) exp_regs[k] = 32'h0000_0000;
    rst_ni = 1'b0;
    s_awaddr_i = 32'h0; s_awvalid_i = 1'b0; s_wdata_i = 32'h0; s_wstrb_i = 4'h0; s_wvalid_i = 1'b0;
    s_araddr_i = 32'h0; s_arvalid_i = 1'b0; s_bready_i = 1'b1; s_rready_i = 1'b1;
    test_reset();
    test_write_read();
    test_skew_backpressure();
    test_out_of_range();
    test_strobe();
    test_same_edge_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
